// File: rtl/lsu_pkg.sv
// Shared constants, FSM encoding and request decode helpers for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic MEM_RW_READ  = 1'b0;
  localparam logic MEM_RW_WRITE = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_WRITE,
    S_RESP
  } state_e;

  // Unsigned stores (funct3[2]=1) do not exist in RV32I.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return |lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response handshake plus DataMemory port of the load/store unit.
interface lsu_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              REQ_VALID;
  logic              REQ_READY;
  logic              REQ_WE;
  logic [2:0]        REQ_FUNCT3;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic [31:0]       REQ_WDATA;
  logic              RSP_VALID;
  logic [31:0]       RSP_RDATA;
  logic              RSP_ERR;
  logic              MEM_RW;
  logic              MEM_EN;
  logic [ADDR_W-1:0] MEM_ADDr;
  logic [31:0]       MEM_DIN;
  logic [31:0]       MEM_DOUT;

  modport master (
    output REQ_VALID, REQ_WE, REQ_FUNCT3, REQ_ADDR, REQ_WDATA,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_FUNCT3, REQ_ADDR, REQ_WDATA, MEM_DOUT,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, MEM_RW, MEM_EN, MEM_ADDr, MEM_DIN
  );

  modport mem (
    input  MEM_RW, MEM_EN, MEM_ADDr, MEM_DIN,
    output MEM_DOUT
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane extract/extend for loads and lane merge for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[{addr_lo, 3'b000} +: 8];
    h = word[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    load_data = {{24{b[7]}}, b};
      F3_H:    load_data = {{16{h[15]}}, h};
      F3_BU:   load_data = {24'h0, b};
      F3_HU:   load_data = {16'h0, h};
      default: load_data = word;
    endcase
  end

  always_comb begin
    store_word = word;
    case (funct3[1:0])
      2'b00:   store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      2'b01:   store_word[{addr_lo[1], 4'b0000} +: 16] = wdata;
      default: store_word = word;
    endcase
  end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller driving DataMemory, with read-modify-write for SB/SH.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses return ERR instead of aligning.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_RD_LAT = 1,
  parameter int unsigned ADDR_W     = 32
) (
  input logic           CLK,
  input logic           RST,
  lsu_mem_ctrl_if.slave bus
);
  localparam logic [1:0] LastCnt = 2'(MEM_RD_LAT - 1);

  state_e            state_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        lane_q;
  logic [15:0]       wdata_q;
  logic [1:0]        cnt_q;
  logic [ADDR_W-1:0] addr_aligned;
  logic              reject;
  logic [31:0]       load_data;
  logic [31:0]       store_word;

  lsu_lane_align u_align (
    .funct3     (f3_q),
    .addr_lo    (lane_q),
    .word       (bus.MEM_DOUT),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_comb begin
    addr_aligned = bus.REQ_ADDR;
    case (bus.REQ_FUNCT3[1:0])
      2'b01:   addr_aligned[0] = 1'b0;
      2'b10:   addr_aligned[1:0] = 2'b00;
      default: addr_aligned = bus.REQ_ADDR;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    reject = f3_illegal(bus.REQ_WE, bus.REQ_FUNCT3) ||
             f3_misaligned(bus.REQ_FUNCT3, bus.REQ_ADDR[1:0]);
`else
    reject = f3_illegal(bus.REQ_WE, bus.REQ_FUNCT3);
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= S_IDLE;
      we_q          <= 1'b0;
      f3_q          <= F3_W;
      lane_q        <= 2'b00;
      wdata_q       <= 16'h0;
      cnt_q         <= 2'b00;
      bus.REQ_READY <= 1'b1;
      bus.RSP_VALID <= 1'b0;
      bus.RSP_RDATA <= 32'h0;
      bus.RSP_ERR   <= 1'b0;
      bus.MEM_EN    <= 1'b0;
      bus.MEM_RW    <= MEM_RW_READ;
      bus.MEM_ADDr  <= '0;
      bus.MEM_DIN   <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.REQ_VALID && bus.REQ_READY) begin
            we_q          <= bus.REQ_WE;
            f3_q          <= bus.REQ_FUNCT3;
            lane_q        <= addr_aligned[1:0];
            wdata_q       <= bus.REQ_WDATA[15:0];
            bus.REQ_READY <= 1'b0;
            if (reject) begin
              bus.RSP_VALID <= 1'b1;
              bus.RSP_ERR   <= 1'b1;
              state_q       <= S_RESP;
            end else begin
              bus.MEM_EN   <= 1'b1;
              bus.MEM_ADDr <= addr_aligned >> 2;
              if (bus.REQ_WE && bus.REQ_FUNCT3 == F3_W) begin
                bus.MEM_RW  <= MEM_RW_WRITE;
                bus.MEM_DIN <= bus.REQ_WDATA;
                state_q     <= S_WRITE;
              end else begin
                bus.MEM_RW <= MEM_RW_READ;
                state_q    <= S_RD_ISSUE;
              end
            end
          end
        end
        S_RD_ISSUE: begin
          bus.MEM_EN <= 1'b0;
          cnt_q      <= 2'b00;
          state_q    <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (cnt_q == LastCnt) begin
            if (we_q) begin
              bus.MEM_EN  <= 1'b1;
              bus.MEM_RW  <= MEM_RW_WRITE;
              bus.MEM_DIN <= store_word;
              state_q     <= S_WRITE;
            end else begin
              bus.RSP_VALID <= 1'b1;
              bus.RSP_ERR   <= 1'b0;
              bus.RSP_RDATA <= load_data;
              state_q       <= S_RESP;
            end
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        S_WRITE: begin
          bus.MEM_EN    <= 1'b0;
          bus.RSP_VALID <= 1'b1;
          bus.RSP_ERR   <= 1'b0;
          state_q       <= S_RESP;
        end
        S_RESP: begin
          bus.RSP_VALID <= 1'b0;
          bus.RSP_ERR   <= 1'b0;
          bus.REQ_READY <= 1'b1;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: vector table + response scoreboard + corner sequences.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  lsu_mem_ctrl_if #(.ADDR_W(32)) b0 ();
  lsu_mem_ctrl_if #(.ADDR_W(32)) b1 ();

  lsu_mem_ctrl #(.MEM_RD_LAT(1), .ADDR_W(32)) dut0 (.CLK(CLK), .RST(RST), .bus(b0));
  lsu_mem_ctrl #(.MEM_RD_LAT(3), .ADDR_W(32)) dut1 (.CLK(CLK), .RST(RST), .bus(b1));

  // Shared memory model: b0 has 1-cycle reads, b1 a 3-stage read pipeline.
  logic [31:0] mem [64];
  logic [31:0] p1a, p1b;
  logic [31:0] last_maddr = 32'h0;
  int en_cnt = 0;
  int wr_cnt = 0;
  int cyc    = 0;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (b0.MEM_EN) begin
      en_cnt     <= en_cnt + 1;
      last_maddr <= b0.MEM_ADDr;
      if (b0.MEM_RW) begin
        mem[b0.MEM_ADDr[5:0]] <= b0.MEM_DIN;
        wr_cnt <= wr_cnt + 1;
      end else begin
        b0.MEM_DOUT <= mem[b0.MEM_ADDr[5:0]];
      end
    end
    if (b1.MEM_EN && !b1.MEM_RW) p1a <= mem[b1.MEM_ADDr[5:0]];
    p1b         <= p1a;
    b1.MEM_DOUT <= p1b;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          hs;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (!RST && b0.RSP_VALID) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 32'(b0.RSP_VALID), 32'h0);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_err", 32'(b0.RSP_ERR), 32'(e.err));
        chk("rsp_rdata", b0.RSP_RDATA, e.rd);
        chk("rsp_latency", 32'(cyc - e.hs + 1), 32'(e.lat));
      end
    end
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          n_en;
    logic [31:0] maddr;
    logic [31:0] memv;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd, input logic err,
                              input int lat, input int n_en, input logic [31:0] maddr,
                              input logic [31:0] memv);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd; v.rd = rd; v.err = err;
    v.lat = lat; v.n_en = n_en; v.maddr = maddr; v.memv = memv;
    return v;
  endfunction

  task automatic start(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input logic err,
                       input int lat);
    exp_t e;
    @(negedge CLK);
    chk("req_ready_idle", 32'(b0.REQ_READY), 32'h1);
    b0.REQ_VALID = 1'b1; b0.REQ_WE = we; b0.REQ_FUNCT3 = f3;
    b0.REQ_ADDR = addr; b0.REQ_WDATA = wd;
    @(posedge CLK);
    #1;
    b0.REQ_VALID = 1'b0;
    e.rd = rd; e.err = err; e.hs = cyc; e.lat = lat;
    sb_q.push_back(e);
  endtask

  task automatic finish_wait();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge CLK);
    if (sb_q.size() != 0) begin
      chk("rsp_timeout", 32'(sb_q.size()), 32'h0);
      sb_q.delete();
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    int en0, wr0, hs;
    logic got;
    b0.REQ_VALID = 1'b0; b0.REQ_WE = 1'b0; b0.REQ_FUNCT3 = 3'b0;
    b0.REQ_ADDR = 32'h0; b0.REQ_WDATA = 32'h0;
    b1.REQ_VALID = 1'b0; b1.REQ_WE = 1'b0; b1.REQ_FUNCT3 = 3'b0;
    b1.REQ_ADDR = 32'h0; b1.REQ_WDATA = 32'h0;

    // Reset values
    repeat (3) @(negedge CLK);
    chk("rst_req_ready", 32'(b0.REQ_READY), 32'h1);
    chk("rst_rsp_valid", 32'(b0.RSP_VALID), 32'h0);
    chk("rst_rsp_rdata", b0.RSP_RDATA, 32'h0);
    chk("rst_mem_en", 32'(b0.MEM_EN), 32'h0);
    chk("rst_mem_addr", b0.MEM_ADDr, 32'h0);
    chk("rst_mem_din", b0.MEM_DIN, 32'h0);
    RST = 1'b0;

    // we, f3, addr, wdata, rsp_rdata, err, latency, mem accesses, last word index, mem word
    vecs.push_back(mk(1, F3_W,  32'h0C, 32'h11223344, 32'h00000000, 0, 2, 1, 3, 32'h11223344));
    vecs.push_back(mk(0, F3_B,  32'h0F, 32'h0,        32'h00000011, 0, 3, 1, 3, 32'h0));
    vecs.push_back(mk(0, F3_H,  32'h0E, 32'h0,        32'h00001122, 0, 3, 1, 3, 32'h0));
    vecs.push_back(mk(0, F3_W,  32'h0C, 32'h0,        32'h11223344, 0, 3, 1, 3, 32'h0));
    vecs.push_back(mk(0, F3_BU, 32'h0D, 32'h0,        32'h00000033, 0, 3, 1, 3, 32'h0));
    vecs.push_back(mk(1, F3_W,  32'h0C, 32'h80FF0000, 32'h00000033, 0, 2, 1, 3, 32'h80FF0000));
    vecs.push_back(mk(0, F3_BU, 32'h0F, 32'h0,        32'h00000080, 0, 3, 1, 3, 32'h0));
    vecs.push_back(mk(0, F3_H,  32'h0E, 32'h0,        32'hFFFF80FF, 0, 3, 1, 3, 32'h0));
    vecs.push_back(mk(0, F3_B,  32'h0E, 32'h0,        32'hFFFFFFFF, 0, 3, 1, 3, 32'h0));
    vecs.push_back(mk(0, F3_HU, 32'h0E, 32'h0,        32'h000080FF, 0, 3, 1, 3, 32'h0));
    vecs.push_back(mk(1, F3_W,  32'h10, 32'hAABBCCDD, 32'h000080FF, 0, 2, 1, 4, 32'hAABBCCDD));
    vecs.push_back(mk(1, F3_B,  32'h11, 32'hFFFFFF55, 32'h000080FF, 0, 4, 2, 4, 32'hAABB55DD));
    vecs.push_back(mk(1, F3_H,  32'h12, 32'h1234BEEF, 32'h000080FF, 0, 4, 2, 4, 32'hBEEF55DD));
    vecs.push_back(mk(0, F3_H,  32'h12, 32'h0,        32'hFFFFBEEF, 0, 3, 1, 4, 32'h0));
    vecs.push_back(mk(0, 3'b011, 32'h10, 32'h0,       32'hFFFFBEEF, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 3'b100, 32'h10, 32'h99,      32'hFFFFBEEF, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 3'b111, 32'h10, 32'h0,       32'hFFFFBEEF, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, F3_W, 32'hFFFFFFFC, 32'hCAFEF00D, 32'hFFFFBEEF, 0, 2, 1, 32'h3FFFFFFF,
                      32'hCAFEF00D));
    vecs.push_back(mk(0, F3_W, 32'hFFFFFFFC, 32'h0, 32'hCAFEF00D, 0, 3, 1, 32'h3FFFFFFF, 32'h0));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk(0, F3_H,  32'h0D, 32'h0,        32'hCAFEF00D, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, F3_W,  32'h13, 32'h0,        32'hCAFEF00D, 1, 1, 0, 0, 32'h0));
`else
    vecs.push_back(mk(0, F3_H,  32'h0D, 32'h0,        32'h00000000, 0, 3, 1, 3, 32'h0));
    vecs.push_back(mk(0, F3_W,  32'h13, 32'h0,        32'hBEEF55DD, 0, 3, 1, 4, 32'h0));
`endif

    foreach (vecs[i]) begin
      en0 = en_cnt;
      start(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, vecs[i].rd, vecs[i].err,
            vecs[i].lat);
      finish_wait();
      chk($sformatf("v%0d_mem_accesses", i), 32'(en_cnt - en0), 32'(vecs[i].n_en));
      if (vecs[i].n_en != 0) chk($sformatf("v%0d_mem_addr", i), last_maddr, vecs[i].maddr);
      if (vecs[i].we && !vecs[i].err)
        chk($sformatf("v%0d_mem_word", i), mem[vecs[i].maddr[5:0]], vecs[i].memv);
    end

    // SW drives the write port one cycle after the handshake; port holds once EN drops.
    start(1, F3_W, 32'h14, 32'h01020304, b0.RSP_RDATA, 0, 2);
    chk("sw_mem_en", 32'(b0.MEM_EN), 32'h1);
    chk("sw_mem_rw", 32'(b0.MEM_RW), 32'h1);
    chk("sw_mem_addr", b0.MEM_ADDr, 32'h5);
    chk("sw_mem_din", b0.MEM_DIN, 32'h01020304);
    chk("sw_req_ready_busy", 32'(b0.REQ_READY), 32'h0);
    finish_wait();
    chk("hold_mem_en", 32'(b0.MEM_EN), 32'h0);
    chk("hold_mem_addr", b0.MEM_ADDr, 32'h5);
    chk("hold_mem_din", b0.MEM_DIN, 32'h01020304);

    // A request presented while busy is dropped, not queued.
    en0 = en_cnt; wr0 = wr_cnt;
    start(0, F3_W, 32'h14, 32'h0, 32'h01020304, 0, 3);
    b0.REQ_VALID = 1'b1; b0.REQ_WE = 1'b1; b0.REQ_FUNCT3 = F3_W;
    b0.REQ_ADDR = 32'h18; b0.REQ_WDATA = 32'hDEADBEEF;
    @(posedge CLK);
    #1;
    b0.REQ_VALID = 1'b0;
    finish_wait();
    repeat (4) @(negedge CLK);
    chk("busy_req_accesses", 32'(en_cnt - en0), 32'h1);
    chk("busy_req_writes", 32'(wr_cnt - wr0), 32'h0);

    // 3-cycle read latency instance: LW response five cycles after the handshake.
    @(negedge CLK);
    b1.REQ_VALID = 1'b1; b1.REQ_WE = 1'b0; b1.REQ_FUNCT3 = F3_W; b1.REQ_ADDR = 32'h10;
    @(posedge CLK);
    #1;
    b1.REQ_VALID = 1'b0;
    hs = cyc;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if (b1.RSP_VALID) begin
        got = 1'b1;
        chk("lat3_latency", 32'(cyc - hs + 1), 32'h5);
        chk("lat3_rdata", b1.RSP_RDATA, 32'hBEEF55DD);
        chk("lat3_err", 32'(b1.RSP_ERR), 32'h0);
      end
    end
    chk("lat3_rsp_seen", 32'(got), 32'h1);

    // Reset during the read phase of an SB: no write, no response.
    start(1, F3_W, 32'h18, 32'h0A0B0C0D, b0.RSP_RDATA, 0, 2);
    finish_wait();
    wr0 = wr_cnt;
    @(negedge CLK);
    b0.REQ_VALID = 1'b1; b0.REQ_WE = 1'b1; b0.REQ_FUNCT3 = F3_B;
    b0.REQ_ADDR = 32'h19; b0.REQ_WDATA = 32'h77;
    @(posedge CLK);
    #1;
    b0.REQ_VALID = 1'b0;
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("rst_mid_mem_en", 32'(b0.MEM_EN), 32'h0);
    chk("rst_mid_rsp_valid", 32'(b0.RSP_VALID), 32'h0);
    chk("rst_mid_rsp_rdata", b0.RSP_RDATA, 32'h0);
    chk("rst_mid_mem_addr", b0.MEM_ADDr, 32'h0);
    chk("rst_mid_mem_din", b0.MEM_DIN, 32'h0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (6) @(negedge CLK);
    chk("rst_mid_no_write", 32'(wr_cnt - wr0), 32'h0);
    chk("rst_mid_mem_word", mem[6], 32'h0A0B0C0D);
    chk("rst_mid_req_ready", 32'(b0.REQ_READY), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Initiator side of the DataMemory port (RW, EN, ADDr, Din, Dout), sitting between the RISC-V execute stage and DataMemory.
- Accepts one load/store request at a time and converts the byte address to a word index.
- Performs read-modify-write for SB/SH, and extracts plus sign/zero-extends LB/LH/LBU/LHU/LW data.
- Returns a single-cycle response pulse per request.

Parameters:
- MEM_RD_LAT, 1, cycles from a read issue (EN=1, RW=0) until MEM_DOUT is valid; legal range 1..4.
- ADDR_W, 32, width of the byte address and of MEM_ADDr.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  controller idle; handshake occurs when REQ_VALID and REQ_READY are both 1 at a rising edge.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_FUNCT3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- REQ_ADDR  in  ADDR_W  byte address.
- REQ_WDATA  in  32  store data; only the low byte/half is used for B/H.
- RSP_VALID  out  1  one-cycle completion pulse.
- RSP_RDATA  out  32  load result, extended.
- RSP_ERR  out  1  request rejected; valid only with RSP_VALID.
- MEM_RW  out  1  1 = write, 0 = read.
- MEM_EN  out  1  memory enable.
- MEM_ADDr  out  ADDR_W  word index, equal to REQ_ADDR>>2.
- MEM_DIN  out  32  write data to DataMemory Din.
- MEM_DOUT  in  32  read data from DataMemory Dout.

Behaviour:
- Interface: one clock CLK; RST is asynchronous, active-high.
- Reset values: REQ_READY=1, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, MEM_EN=0, MEM_RW=0, MEM_ADDr=0, MEM_DIN=0, FSM=IDLE.
- All outputs are registered.

State machine:
- IDLE: REQ_READY=1. On handshake, latch the request; REQ_READY drops next cycle.
  - Illegal encoding -> RESP with ERR. Illegal means funct3 011/110/111, or a store with funct3[2]=1.
  - Word store -> WRITE.
  - Any other request -> RD_ISSUE.
- RD_ISSUE: one cycle, MEM_EN=1, MEM_RW=0 -> RD_WAIT.
- RD_WAIT: MEM_EN=0. Count MEM_RD_LAT cycles and capture MEM_DOUT on the last one.
  - Load -> RESP.
  - Sub-word store -> WRITE.
- WRITE: one cycle, MEM_EN=1, MEM_RW=1.
  - Word store: MEM_DIN = REQ_WDATA.
  - Sub-word store: MEM_DIN = captured word with only the addressed lane replaced. Byte lane = ADDR[1:0]; half lane = ADDR[1].
  - Next state: RESP.
- RESP: RSP_VALID=1 for exactly one cycle -> IDLE; REQ_READY=1 again in the next cycle.

Latency with MEM_RD_LAT=1, where handshake is at edge T:
- Error: RSP_VALID during T+1.
- SW: RSP_VALID during T+2.
- Loads: RSP_VALID during T+3.
- SB/SH: RSP_VALID during T+4.

Data rules:
- Load extraction is little-endian.
- B/H are sign-extended from bit 7/15; BU/HU are zero-extended.
- RSP_RDATA holds its value until the next RSP_VALID. Stores and errors leave it unchanged.

Boundary conditions:
- MEM_ADDr and MEM_DIN hold their last values while MEM_EN=0.
- REQ_VALID outside IDLE is ignored; it is not queued.
- No other memory access is issued for an error response.
- Address wrap-around: ADDR_W-bit arithmetic, no overflow detection.
- RST mid-operation: all outputs return to reset values immediately (asynchronously). MEM_EN dropping suppresses any pending write, so there is no partial RMW, and the in-flight request is discarded with no response.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a half with ADDR[0]=1, or a word with ADDR[1:0]!=0, produces an ERR response at T+1 with no memory access.
- Undefined: the low address bits are forced to natural alignment (half clears bit 0, word clears bits 1:0) and the access proceeds normally; RSP_ERR is asserted only for illegal funct3.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state encodings S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_WRITE, S_RESP;
  - MEM_RW_READ=0 and MEM_RW_WRITE=1.
- Sub-module lsu_lane_align (combinational) does load extract/extend and store lane merge. It is reused by the future instruction-fetch path.

Test Plan:
- Reset then SW addr 0x0C, data 0x11223344: MEM_EN=1, RW=1, MEM_ADDr=3, MEM_DIN=0x11223344 at T+1; RSP_VALID at T+2, ERR=0.
- Memory word 3 = 0x11223344, LB addr 0x0F: 0x00000011. LH addr 0x0E: 0x00001122. Memory word 3 = 0x80FF0000, LBU addr 0x0F: 0x00000080. LH addr 0x0E: 0xFFFF80FF.
- Memory word 4 = 0xAABBCCDD, SB addr 0x11, data 0x55: read then write with MEM_DIN=0xAABB55DD; RSP_VALID at T+4.
- funct3=011 load: RSP_VALID with ERR=1 at T+1, MEM_EN never asserted. LH addr 0x0D: ERR=1 with LSU_MISALIGN_TRAP_EN defined; reads word 3 lane 0 without it.
- MEM_RD_LAT=3 LW: RSP_VALID at T+5. Assert RST during the RD_WAIT of an SB: MEM_EN=0 immediately, no write ever, no response; REQ_READY=1 after RST release.
